// File: rtl/branch_resolve_ctrl_if.sv
// Fetch / predictor / execute handshake bundle for the branch resolve controller.
// The slave modport is the controller's view; master is the surrounding pipeline.
interface branch_resolve_ctrl_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PC_W  = 16
);
  localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

  // Fetch side
  logic              fetchValid;
  logic [PC_W-1:0]   fetchPC;
  logic              fetchStall;
  logic              fetchTaken;
  // Predictor read
  logic              predict;
  logic [PC_W-1:0]   predictPC;
  logic              prediction;
  // Execute resolve
  logic              resolveValid;
  logic              resolveTaken;
  // Predictor training
  logic              update;
  logic [PC_W-1:0]   updatePC;
  logic              reality;
  logic              mispredict;
  // Status
  logic [OCC_W-1:0]  occupancy;
  logic              resolveError;

  modport slave (
    input  fetchValid, fetchPC, prediction, resolveValid, resolveTaken,
    output fetchStall, fetchTaken, predict, predictPC, update, updatePC, reality,
           mispredict, occupancy, resolveError
  );

  modport master (
    output fetchValid, fetchPC, prediction, resolveValid, resolveTaken,
    input  fetchStall, fetchTaken, predict, predictPC, update, updatePC, reality,
           mispredict, occupancy, resolveError
  );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// Branch resolve controller: tracks in-flight predicted branches in an in-order
// FIFO, trains the predictor when execute resolves the oldest one, and flushes
// all younger branches on a misprediction.
module branch_resolve_ctrl #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PC_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  branch_resolve_ctrl_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  // Tracker storage; entry validity is implied by head/occupancy, so the data
  // arrays need no reset.
  logic [PC_W-1:0]  pc_q   [DEPTH];
  logic [PC_W-1:0]  pc_d   [DEPTH];
  logic             pred_q [DEPTH];
  logic             pred_d [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [OCC_W-1:0] occ_q, occ_d;

  logic             update_q, update_d;
  logic [PC_W-1:0]  update_pc_q, update_pc_d;
  logic             reality_q, reality_d;
  logic             mispredict_q, mispredict_d;
  logic             resolve_error_q, resolve_error_d;

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             mismatch;

  // Fetch-side handshake and push/pop qualification
  always_comb begin
    full     = (occ_q == OCC_W'(DEPTH));
    empty    = (occ_q == '0);
    push     = bus.fetchValid & ~full & ~reset;
    pop      = bus.resolveValid & ~empty & ~reset;
    mismatch = pop & (bus.resolveTaken != pred_q[head_q]);
  end

  assign bus.fetchStall   = full;
  assign bus.predict      = push;
  assign bus.predictPC    = bus.fetchPC;
  assign bus.fetchTaken   = push & bus.prediction;
  assign bus.update       = update_q;
  assign bus.updatePC     = update_pc_q;
  assign bus.reality      = reality_q;
  assign bus.mispredict   = mispredict_q;
  assign bus.occupancy    = occ_q;
  assign bus.resolveError = resolve_error_q;

  // Next-state for tracker pointers, storage and training outputs
  always_comb begin
    pc_d            = pc_q;
    pred_d          = pred_q;
    head_d          = head_q;
    tail_d          = tail_q;
    occ_d           = occ_q;
    update_d        = pop;
    mispredict_d    = mismatch;
    update_pc_d     = update_pc_q;
    reality_d       = reality_q;
    resolve_error_d = resolve_error_q | (bus.resolveValid & empty);

    if (pop) begin
      update_pc_d = pc_q[head_q];
      reality_d   = bus.resolveTaken;
    end

    if (mismatch) begin
      // Everything younger than the head was fetched down the wrong path,
      // including a push offered on this same edge.
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
    end else begin
      if (push) begin
        pc_d[tail_q]   = bus.fetchPC;
        pred_d[tail_q] = bus.prediction;
        tail_d         = tail_q + PTR_W'(1);
      end
      if (pop) begin
        head_d = head_q + PTR_W'(1);
      end
      occ_d = occ_q + OCC_W'(push) - OCC_W'(pop);
    end
  end

  // State registers with synchronous reset; reset drops in-flight branches
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q          <= '0;
      tail_q          <= '0;
      occ_q           <= '0;
      update_q        <= 1'b0;
      update_pc_q     <= '0;
      reality_q       <= 1'b0;
      mispredict_q    <= 1'b0;
      resolve_error_q <= 1'b0;
    end else begin
      head_q          <= head_d;
      tail_q          <= tail_d;
      occ_q           <= occ_d;
      update_q        <= update_d;
      update_pc_q     <= update_pc_d;
      reality_q       <= reality_d;
      mispredict_q    <= mispredict_d;
      resolve_error_q <= resolve_error_d;
    end
  end

  // Tracker data storage
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      pc_q[i]   <= pc_d[i];
      pred_q[i] <= pred_d[i];
    end
  end

  // Occupancy must stay within the tracker bounds
  a_occ_bound: assert property (@(posedge clk) disable iff (reset) occ_q <= OCC_W'(DEPTH));

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl: reset, train, correct, full, flush,
// wrap-around and mid-operation reset scenarios.
module tb_branch_resolve_ctrl;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PC_W  = 16;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  branch_resolve_ctrl_if #(.DEPTH(DEPTH), .PC_W(PC_W)) bus ();

  branch_resolve_ctrl #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.fetchValid   = 1'b0;
    bus.fetchPC      = '0;
    bus.prediction   = 1'b0;
    bus.resolveValid = 1'b0;
    bus.resolveTaken = 1'b0;
  endtask

  task automatic push_one(input logic [PC_W-1:0] pc, input logic pred);
    bus.fetchValid = 1'b1;
    bus.fetchPC    = pc;
    bus.prediction = pred;
    tick();
    bus.fetchValid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    bus.fetchValid   = 1'b1;
    bus.fetchPC      = 16'h1234;
    bus.prediction   = 1'b1;
    bus.resolveValid = 1'b1;
    tick();
    tick();
    checks++; if (bus.predict !== 1'b0) begin errors++; $display("FAIL rst_predict got %b exp 0", bus.predict); end
    checks++; if (bus.fetchTaken !== 1'b0) begin errors++; $display("FAIL rst_taken got %b exp 0", bus.fetchTaken); end
    idle();
    reset = 1'b0;
    #1;
    checks++; if (bus.occupancy !== 3'd0) begin errors++; $display("FAIL rst_occ got %0d exp 0", bus.occupancy); end
    checks++; if (bus.update !== 1'b0) begin errors++; $display("FAIL rst_update got %b exp 0", bus.update); end
    checks++; if (bus.mispredict !== 1'b0) begin errors++; $display("FAIL rst_mis got %b exp 0", bus.mispredict); end
    checks++; if (bus.updatePC !== 16'h0) begin errors++; $display("FAIL rst_updpc got %h exp 0000", bus.updatePC); end
    checks++; if (bus.reality !== 1'b0) begin errors++; $display("FAIL rst_reality got %b exp 0", bus.reality); end
    checks++; if (bus.resolveError !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", bus.resolveError); end
    checks++; if (bus.fetchStall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b exp 0", bus.fetchStall); end
  endtask

  task automatic test_basic_train();
    bus.fetchValid = 1'b1;
    bus.fetchPC    = 16'h00AA;
    bus.prediction = 1'b1;
    #1;
    checks++; if (bus.predict !== 1'b1) begin errors++; $display("FAIL train_predict got %b exp 1", bus.predict); end
    checks++; if (bus.predictPC !== 16'h00AA) begin errors++; $display("FAIL train_ppc got %h exp 00aa", bus.predictPC); end
    checks++; if (bus.fetchTaken !== 1'b1) begin errors++; $display("FAIL train_taken got %b exp 1", bus.fetchTaken); end
    tick();
    idle();
    #1;
    checks++; if (bus.occupancy !== 3'd1) begin errors++; $display("FAIL train_occ1 got %0d exp 1", bus.occupancy); end
    // prediction=1 without fetchValid must not reach fetchTaken
    bus.prediction = 1'b1;
    #1;
    checks++; if (bus.fetchTaken !== 1'b0) begin errors++; $display("FAIL train_taken_idle got %b exp 0", bus.fetchTaken); end
    bus.prediction   = 1'b0;
    bus.resolveValid = 1'b1;
    bus.resolveTaken = 1'b0;
    tick();
    idle();
    checks++; if (bus.update !== 1'b1) begin errors++; $display("FAIL train_update got %b exp 1", bus.update); end
    checks++; if (bus.updatePC !== 16'h00AA) begin errors++; $display("FAIL train_updpc got %h exp 00aa", bus.updatePC); end
    checks++; if (bus.reality !== 1'b0) begin errors++; $display("FAIL train_reality got %b exp 0", bus.reality); end
    checks++; if (bus.mispredict !== 1'b1) begin errors++; $display("FAIL train_mis got %b exp 1", bus.mispredict); end
    checks++; if (bus.occupancy !== 3'd0) begin errors++; $display("FAIL train_occ0 got %0d exp 0", bus.occupancy); end
    // resolveTaken alone must be ignored
    bus.resolveTaken = 1'b1;
    tick();
    bus.resolveTaken = 1'b0;
    checks++; if (bus.update !== 1'b0) begin errors++; $display("FAIL train_upd_pulse got %b exp 0", bus.update); end
    checks++; if (bus.mispredict !== 1'b0) begin errors++; $display("FAIL train_mis_pulse got %b exp 0", bus.mispredict); end
    checks++; if (bus.updatePC !== 16'h00AA) begin errors++; $display("FAIL train_updpc_hold got %h exp 00aa", bus.updatePC); end
    checks++; if (bus.reality !== 1'b0) begin errors++; $display("FAIL train_reality_hold got %b exp 0", bus.reality); end
    checks++; if (bus.resolveError !== 1'b0) begin errors++; $display("FAIL train_err got %b exp 0", bus.resolveError); end
  endtask

  task automatic test_correct();
    push_one(16'h0010, 1'b0);
    bus.resolveValid = 1'b1;
    bus.resolveTaken = 1'b0;
    tick();
    idle();
    checks++; if (bus.update !== 1'b1) begin errors++; $display("FAIL corr_update got %b exp 1", bus.update); end
    checks++; if (bus.updatePC !== 16'h0010) begin errors++; $display("FAIL corr_updpc got %h exp 0010", bus.updatePC); end
    checks++; if (bus.reality !== 1'b0) begin errors++; $display("FAIL corr_reality got %b exp 0", bus.reality); end
    checks++; if (bus.mispredict !== 1'b0) begin errors++; $display("FAIL corr_mis got %b exp 0", bus.mispredict); end
    checks++; if (bus.occupancy !== 3'd0) begin errors++; $display("FAIL corr_occ got %0d exp 0", bus.occupancy); end
  endtask

  task automatic test_full();
    logic [PC_W-1:0] exp_pc;
    for (int i = 0; i < 4; i++) push_one(16'h0100 + 16'(i), 1'b0);
    bus.fetchValid = 1'b1;
    bus.fetchPC    = 16'h0104;
    bus.prediction = 1'b1;
    #1;
    checks++; if (bus.occupancy !== 3'd4) begin errors++; $display("FAIL full_occ got %0d exp 4", bus.occupancy); end
    checks++; if (bus.fetchStall !== 1'b1) begin errors++; $display("FAIL full_stall got %b exp 1", bus.fetchStall); end
    checks++; if (bus.predict !== 1'b0) begin errors++; $display("FAIL full_predict got %b exp 0", bus.predict); end
    checks++; if (bus.fetchTaken !== 1'b0) begin errors++; $display("FAIL full_taken got %b exp 0", bus.fetchTaken); end
    bus.resolveValid = 1'b1;
    bus.resolveTaken = 1'b0;
    #1;
    checks++; if (bus.fetchStall !== 1'b1) begin errors++; $display("FAIL full_stall_resolve got %b exp 1", bus.fetchStall); end
    tick();
    bus.fetchValid   = 1'b0;
    bus.resolveValid = 1'b0;
    checks++; if (bus.updatePC !== 16'h0100) begin errors++; $display("FAIL full_updpc got %h exp 0100", bus.updatePC); end
    checks++; if (bus.mispredict !== 1'b0) begin errors++; $display("FAIL full_mis got %b exp 0", bus.mispredict); end
    checks++; if (bus.occupancy !== 3'd3) begin errors++; $display("FAIL full_occ3 got %0d exp 3", bus.occupancy); end
    checks++; if (bus.fetchStall !== 1'b0) begin errors++; $display("FAIL full_unstall got %b exp 0", bus.fetchStall); end
    for (int i = 1; i < 4; i++) begin
      exp_pc = 16'h0100 + 16'(i);
      bus.resolveValid = 1'b1;
      tick();
      bus.resolveValid = 1'b0;
      checks++; if (bus.updatePC !== exp_pc) begin errors++; $display("FAIL full_drain%0d got %h exp %h", i, bus.updatePC, exp_pc); end
    end
    checks++; if (bus.occupancy !== 3'd0) begin errors++; $display("FAIL full_drained got %0d exp 0", bus.occupancy); end
  endtask

  task automatic test_flush();
    push_one(16'h0200, 1'b1);
    push_one(16'h0201, 1'b0);
    push_one(16'h0202, 1'b0);
    bus.fetchValid   = 1'b1;
    bus.fetchPC      = 16'h0203;
    bus.prediction   = 1'b0;
    bus.resolveValid = 1'b1;
    bus.resolveTaken = 1'b0;
    tick();
    idle();
    checks++; if (bus.mispredict !== 1'b1) begin errors++; $display("FAIL flush_mis got %b exp 1", bus.mispredict); end
    checks++; if (bus.update !== 1'b1) begin errors++; $display("FAIL flush_update got %b exp 1", bus.update); end
    checks++; if (bus.updatePC !== 16'h0200) begin errors++; $display("FAIL flush_updpc got %h exp 0200", bus.updatePC); end
    checks++; if (bus.occupancy !== 3'd0) begin errors++; $display("FAIL flush_occ got %0d exp 0", bus.occupancy); end
    tick();
    checks++; if (bus.update !== 1'b0) begin errors++; $display("FAIL flush_single got %b exp 0", bus.update); end
    bus.resolveValid = 1'b1;
    tick();
    bus.resolveValid = 1'b0;
    checks++; if (bus.update !== 1'b0) begin errors++; $display("FAIL flush_late_upd got %b exp 0", bus.update); end
    checks++; if (bus.mispredict !== 1'b0) begin errors++; $display("FAIL flush_late_mis got %b exp 0", bus.mispredict); end
    checks++; if (bus.resolveError !== 1'b1) begin errors++; $display("FAIL flush_err got %b exp 1", bus.resolveError); end
    checks++; if (bus.occupancy !== 3'd0) begin errors++; $display("FAIL flush_occ_late got %0d exp 0", bus.occupancy); end
    // Pointers restart at zero: a fresh push must be the next one popped
    push_one(16'h0210, 1'b1);
    bus.resolveValid = 1'b1;
    bus.resolveTaken = 1'b1;
    tick();
    idle();
    checks++; if (bus.updatePC !== 16'h0210) begin errors++; $display("FAIL flush_restart_pc got %h exp 0210", bus.updatePC); end
    checks++; if (bus.mispredict !== 1'b0) begin errors++; $display("FAIL flush_restart_mis got %b exp 0", bus.mispredict); end
    checks++; if (bus.resolveError !== 1'b1) begin errors++; $display("FAIL flush_err_sticky got %b exp 1", bus.resolveError); end
  endtask

  task automatic test_back_to_back();
    logic [PC_W-1:0] exp_pc;
    logic            exp_r;
    push_one(16'h0300, 1'b0);
    push_one(16'h0301, 1'b1);
    for (int i = 0; i < 10; i++) begin
      exp_pc = 16'h0300 + 16'(i);
      exp_r  = 1'(i & 1);
      bus.fetchValid   = 1'b1;
      bus.fetchPC      = 16'h0302 + 16'(i);
      bus.prediction   = exp_r;
      bus.resolveValid = 1'b1;
      bus.resolveTaken = exp_r;
      tick();
      checks++; if (bus.updatePC !== exp_pc) begin errors++; $display("FAIL wrap_pc%0d got %h exp %h", i, bus.updatePC, exp_pc); end
      checks++; if (bus.reality !== exp_r || bus.update !== 1'b1 || bus.mispredict !== 1'b0) begin
        errors++; $display("FAIL wrap_flags%0d got r%b u%b m%b exp r%b u1 m0", i, bus.reality, bus.update, bus.mispredict, exp_r);
      end
      checks++; if (bus.occupancy !== 3'd2) begin errors++; $display("FAIL wrap_occ%0d got %0d exp 2", i, bus.occupancy); end
    end
    idle();
    for (int i = 0; i < 2; i++) begin
      exp_pc = 16'h030A + 16'(i);
      bus.resolveValid = 1'b1;
      bus.resolveTaken = 1'(i & 1);
      tick();
      checks++; if (bus.updatePC !== exp_pc || bus.mispredict !== 1'b0) begin
        errors++; $display("FAIL wrap_drain%0d got %h m%b exp %h m0", i, bus.updatePC, bus.mispredict, exp_pc);
      end
    end
    idle();
    tick();
  endtask

  task automatic test_reset_mid();
    push_one(16'h0400, 1'b1);
    push_one(16'h0401, 1'b0);
    reset            = 1'b1;
    bus.resolveValid = 1'b1;
    bus.resolveTaken = 1'b0;
    tick();
    checks++; if (bus.occupancy !== 3'd0) begin errors++; $display("FAIL rmid_occ got %0d exp 0", bus.occupancy); end
    checks++; if (bus.update !== 1'b0) begin errors++; $display("FAIL rmid_update got %b exp 0", bus.update); end
    checks++; if (bus.mispredict !== 1'b0) begin errors++; $display("FAIL rmid_mis got %b exp 0", bus.mispredict); end
    checks++; if (bus.resolveError !== 1'b0) begin errors++; $display("FAIL rmid_err got %b exp 0", bus.resolveError); end
    reset = 1'b0;
    idle();
    tick();
    checks++; if (bus.update !== 1'b0) begin errors++; $display("FAIL rmid_no_upd got %b exp 0", bus.update); end
    push_one(16'h0410, 1'b0);
    bus.resolveValid = 1'b1;
    tick();
    idle();
    checks++; if (bus.updatePC !== 16'h0410) begin errors++; $display("FAIL rmid_restart got %h exp 0410", bus.updatePC); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    idle();
    test_reset();
    test_basic_train();
    test_correct();
    test_full();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve_ctrl.md
BRANCH_RESOLVE_CTRL -- requirements
Module: branch_resolve_ctrl

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  DEPTH, 4, in-flight branch tracker entries; power of 2, >= 2
  PC_W, 16, PC width
REQ-002 Ports SHALL be, one per line (name  direction  width  meaning):
  clk  in  1  single clock; all state changes on rising edge
  reset  in  1  synchronous, active-high reset
  fetchValid  in  1  fetch holds a branch at fetchPC needing a prediction
  fetchPC  in  PC_W  PC of the fetched branch
  fetchStall  out  1  tracker full; fetch holds its branch
  fetchTaken  out  1  prediction returned to fetch
  predict  out  1  predictor read strobe
  predictPC  out  PC_W  predictor read PC
  prediction  in  1  predictor result; valid in the same cycle as predict
  resolveValid  in  1  execute resolves the oldest in-flight branch
  resolveTaken  in  1  actual branch outcome
  update  out  1  predictor training strobe (registered)
  updatePC  out  PC_W  predictor training PC (registered)
  reality  out  1  predictor training outcome (registered)
  mispredict  out  1  one-cycle pulse: resolved outcome differed from prediction
  occupancy  out  log2(DEPTH)+1  live tracker entry count
  resolveError  out  1  sticky: resolve received with tracker empty

Function
REQ-003 Tracker SHALL be an in-order FIFO of DEPTH entries {pc, predTaken} with head/tail pointers wrapping modulo DEPTH.
REQ-004 fetchStall SHALL be combinational: 1 iff occupancy == DEPTH; a same-cycle resolve does not lift it.
REQ-005 predict SHALL equal fetchValid & ~fetchStall & ~reset; predictPC SHALL equal fetchPC; fetchTaken SHALL equal prediction when predict=1, else 0.
REQ-006 On an edge with predict=1, tracker SHALL push {fetchPC, prediction} at tail.
REQ-007 On an edge with resolveValid=1 and occupancy>0, tracker SHALL pop head; next cycle update=1, updatePC=popped pc, reality=resolveTaken, mispredict=(resolveTaken != popped predTaken).
REQ-008 update and mispredict SHALL be 1 for exactly one cycle per pop and 0 otherwise; updatePC/reality SHALL hold last value when update=0.
REQ-009 Mispredict flush: on a popping edge that detects a mismatch, all remaining entries and any same-edge push SHALL be discarded; occupancy=0 and pointers=0 next cycle.
REQ-010 Push and non-mispredicting pop on the same edge SHALL leave occupancy unchanged and advance both pointers.
REQ-011 resolveValid with occupancy==0 SHALL cause no pop, no update, no mispredict, and SHALL set resolveError until reset.
REQ-012 resolveTaken SHALL be ignored when resolveValid=0.
REQ-013 occupancy SHALL never exceed DEPTH nor underflow below 0.

Reset
REQ-014 When reset=1 at an edge: occupancy=0, pointers=0, update=0, mispredict=0, updatePC=0, reality=0, resolveError=0; all entries invalid.
REQ-015 While reset=1, predict=0 and no push/pop SHALL occur regardless of fetchValid/resolveValid; reset mid-operation discards all in-flight branches without issuing updates.

Verification
REQ-016 Basic train: push PC 0x00AA with prediction=1, then resolveValid=1/resolveTaken=0 -> next cycle update=1, updatePC=0x00AA, reality=0, mispredict=1, occupancy=0.
REQ-017 Correct prediction: push 0x0010 (pred 0), resolve taken=0 -> update=1, reality=0, mispredict=0, no flush.
REQ-018 Full/stall: 4 pushes 0x0100..0x0103 -> occupancy=4, fetchStall=1, predict=0 with fetchValid=1; one correct resolve -> updatePC=0x0100, occupancy=3, fetchStall=0.
REQ-019 Flush: 3 entries, head mispredicts while a push is offered same edge -> mispredict=1, single update for head only, occupancy=0, later resolves produce no update and set resolveError.
REQ-020 Wrap-around: 10 push/resolve pairs with simultaneous push+pop -> updatePC sequence matches push order exactly, occupancy steady.
REQ-021 Reset mid-operation: reset with 2 entries -> occupancy=0, update=0, resolveError=0, no update issued for discarded entries.
